// File: rtl/banked_ram.sv
// Banked synchronous RAM with per-bank write protection and an optional
// post-reset fill. All banks are cleared in parallel, one offset per cycle.
// Handshake: an access is accepted on a rising clock edge when ready=1 and
// select=1; rw chooses read (1) or write (0). Read data appears on dataOut
// one cycle after the accepting edge and is held until the next accepted read.
module banked_ram #(
    parameter int                    ADDR_WIDTH     = 12,
    parameter int                    BANK_BITS      = 3,
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE     = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [ADDR_WIDTH-1:0]       address,
    input  logic                        select,
    input  logic                        rw,
    input  logic [DATA_WIDTH-1:0]       dataIn,
    input  logic [(1<<BANK_BITS)-1:0]   writeProtect,
    output logic [DATA_WIDTH-1:0]       dataOut,
    output logic                        ready,
    output logic                        protectFault
);

    localparam int NUM_BANKS = 1 << BANK_BITS;
    localparam int OFF_W     = ADDR_WIDTH - BANK_BITS;
    localparam logic [OFF_W-1:0] OFF_MAX = '1;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    state_t                 state_q, state_d;
    logic [OFF_W-1:0]       cnt_q, cnt_d;
    logic                   ready_q;
    logic                   fault_q;
    logic                   rd_valid_q;
    logic [BANK_BITS-1:0]   bank_q;

    logic [BANK_BITS-1:0]   bank_sel;
    logic [OFF_W-1:0]       offset;
    logic                   acc_rd, acc_wr, acc_fault, clr_we;
    logic [DATA_WIDTH-1:0]  rd_data [NUM_BANKS];

    assign bank_sel  = address[ADDR_WIDTH-1 -: BANK_BITS];
    assign offset    = address[OFF_W-1:0];
    // ready_q gates every access, so nothing is accepted during reset or CLEAR.
    assign acc_rd    = ready_q & select & rw;
    assign acc_wr    = ready_q & select & ~rw & ~writeProtect[bank_sel];
    assign acc_fault = ready_q & select & ~rw &  writeProtect[bank_sel];
    // The fill ignores writeProtect; it is held off while reset is asserted so
    // reset itself never touches memory.
    assign clr_we    = (state_q == S_CLEAR) & ~reset;

    // Next-state logic: step through all offsets in CLEAR, then settle in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == OFF_MAX) begin
                state_d = S_IDLE;
            end
        end
    end

    // Control registers: state, clear counter, ready, fault pulse, read bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            bank_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == S_IDLE);
            fault_q <= acc_fault;
            if (acc_rd) begin
                rd_valid_q <= 1'b1;
                bank_q     <= bank_sel;
            end
        end
    end

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [0:(1<<OFF_W)-1];
        logic [DATA_WIDTH-1:0] rd_q;

        // One block RAM per bank: fill or user write port, registered read port.
        always_ff @(posedge clock) begin
            if (clr_we) begin
                mem[cnt_q] <= FILL_VALUE;
            end else if (acc_wr && (bank_sel == BANK_BITS'(gb))) begin
                mem[offset] <= dataIn;
            end
            if (acc_rd && (bank_sel == BANK_BITS'(gb))) begin
                rd_q <= mem[offset];
            end
        end

        assign rd_data[gb] = rd_q;
    end

    // Until the first accepted read after reset, dataOut shows all-ones.
    assign dataOut      = rd_valid_q ? rd_data[bank_q] : '1;
    assign ready        = ready_q;
    assign protectFault = fault_q;

endmodule

// File: tb/tb_banked_ram.sv
// Self-checking bench for banked_ram: default instance plus a parameter-sweep
// instance. Read expectations go through a scoreboard queue.
module tb_banked_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        reset = 1'b1;
    logic [11:0] address = '0;
    logic        select = 1'b0;
    logic        rw = 1'b1;
    logic [7:0]  dataIn = '0;
    logic [7:0]  wp = '0;
    logic [7:0]  dataOut;
    logic        ready;
    logic        fault;

    // sweep instance
    logic        p_reset = 1'b1;
    logic [9:0]  p_address = '0;
    logic        p_select = 1'b0;
    logic        p_rw = 1'b1;
    logic [15:0] p_dataIn = '0;
    logic [3:0]  p_wp = '0;
    logic [15:0] p_dataOut;
    logic        p_ready;
    logic        p_fault;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    banked_ram dut (
        .clock(clk), .reset(reset), .address(address), .select(select),
        .rw(rw), .dataIn(dataIn), .writeProtect(wp), .dataOut(dataOut),
        .ready(ready), .protectFault(fault)
    );

    banked_ram #(
        .ADDR_WIDTH(10), .BANK_BITS(2), .DATA_WIDTH(16),
        .CLEAR_ON_RESET(1), .FILL_VALUE(16'hBEEF)
    ) dut_p (
        .clock(clk), .reset(p_reset), .address(p_address), .select(p_select),
        .rw(p_rw), .dataIn(p_dataIn), .writeProtect(p_wp), .dataOut(p_dataOut),
        .ready(p_ready), .protectFault(p_fault)
    );

    // ---------------- driver tasks ----------------
    task automatic rd(input logic [11:0] a, input logic [7:0] exp, input string name);
        logic [15:0] e;
        @(negedge clk);
        address = a; rw = 1'b1; select = 1'b1;
        exp_q.push_back({8'h00, exp});
        @(posedge clk); #1;
        select = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({8'h00, dataOut} !== e) begin
            errors++;
            $display("FAIL %s: dataOut=%h expected=%h", name, dataOut, e[7:0]);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d, input logic exp_fault,
                      input string name);
        @(negedge clk);
        address = a; dataIn = d; rw = 1'b0; select = 1'b1;
        @(posedge clk); #1;
        select = 1'b0; rw = 1'b1;
        checks++;
        if (fault !== exp_fault) begin
            errors++;
            $display("FAIL %s: protectFault=%b expected=%b", name, fault, exp_fault);
        end
    endtask

    task automatic p_rd(input logic [9:0] a, input logic [15:0] exp, input string name);
        logic [15:0] e;
        @(negedge clk);
        p_address = a; p_rw = 1'b1; p_select = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        p_select = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (p_dataOut !== e) begin
            errors++;
            $display("FAIL %s: dataOut=%h expected=%h", name, p_dataOut, e);
        end
    endtask

    // Count rising edges until ready rises; bounded so a stuck DUT still ends.
    task automatic count_clear(input bit sweep, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(sweep ? p_ready : ready) && n < 2000);
    endtask

    task automatic check_cycles(input int n, input int exp, input string name);
        checks++;
        if (n !== exp) begin
            errors++;
            $display("FAIL %s: clear cycles=%0d expected=%0d", name, n, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n;
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (dataOut !== 8'hFF) begin errors++; $display("FAIL reset_dataOut: %h expected ff", dataOut); end
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: %b expected 0", ready); end
        if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: %b expected 0", fault); end
        @(negedge clk); reset = 1'b0;
        count_clear(1'b0, n);
        check_cycles(n, 512, "clear_len");
        rd(12'h000, 8'h00, "rd_000");
        rd(12'h1FF, 8'h00, "rd_1ff");
        rd(12'hE00, 8'h00, "rd_e00");
        rd(12'hFFF, 8'h00, "rd_fff");
    endtask

    task automatic test_write_read();
        wr(12'h3FF, 8'hA5, 1'b0, "wr_3ff");
        rd(12'h3FF, 8'hA5, "rd_3ff");
        @(posedge clk); #1;
        checks++;
        if (dataOut !== 8'hA5) begin errors++; $display("FAIL hold: dataOut=%h expected a5", dataOut); end
        rd(12'h5FF, 8'h00, "rd_5ff_other_bank");
    endtask

    task automatic test_protect();
        wp = 8'b0000_0100;
        wr(12'h400, 8'h5A, 1'b1, "fault_400");
        @(posedge clk); #1;
        checks++;
        if (fault !== 1'b0) begin errors++; $display("FAIL fault_one_cycle: %b expected 0", fault); end
        rd(12'h400, 8'h00, "rd_400_unchanged");
        wr(12'h200, 8'h5A, 1'b0, "wr_200_nofault");
        rd(12'h200, 8'h5A, "rd_200");
        // back-to-back faulting writes keep the pulse high on each cycle
        wr(12'h401, 8'h11, 1'b1, "fault_b2b_1");
        wr(12'h402, 8'h22, 1'b1, "fault_b2b_2");
        @(posedge clk); #1;
        checks++;
        if (fault !== 1'b0) begin errors++; $display("FAIL fault_b2b_end: %b expected 0", fault); end
        rd(12'h401, 8'h00, "rd_401_unchanged");
        wp = '0;
    endtask

    task automatic test_back_to_back();
        logic [11:0] a [8];
        logic [7:0]  d [8];
        for (int b = 0; b < 8; b++) begin
            a[b] = {3'(b), 9'($urandom_range(0, 511))};
            d[b] = 8'($urandom_range(0, 255));
            wr(a[b], d[b], 1'b0, "rand_wr");
        end
        for (int b = 0; b < 8; b++) begin
            rd(a[b], d[b], "rand_rd");
        end
        wr(12'h777, 8'h3C, 1'b0, "raw_wr");
        rd(12'h777, 8'h3C, "raw_rd");
    endtask

    task automatic test_reset_mid_clear();
        int n;
        wr(12'h123, 8'h77, 1'b0, "seed_wr");
        rd(12'h123, 8'h77, "seed_rd");
        pulse_reset();
        repeat (100) @(posedge clk);
        #1; reset = 1'b1;
        #1;
        checks += 2;
        if (ready !== 1'b0) begin errors++; $display("FAIL midclear_ready: %b expected 0", ready); end
        if (dataOut !== 8'hFF) begin errors++; $display("FAIL midclear_dataOut: %h expected ff", dataOut); end
        wp = '1;   // protection must not block the fill
        @(negedge clk); reset = 1'b0;
        count_clear(1'b0, n);
        check_cycles(n, 512, "clear_restart_len");
        wp = '0;
        rd(12'h123, 8'h00, "seed_cleared");
    endtask

    task automatic test_clear_access();
        int n;
        pulse_reset();
        repeat (300) @(posedge clk);   // offset 0x010 already filled
        wr(12'h010, 8'hFF, 1'b0, "clear_wr_nofault");
        checks++;
        if (dataOut !== 8'hFF) begin errors++; $display("FAIL clear_wr_dataOut: %h expected ff", dataOut); end
        rd(12'h010, 8'hFF, "clear_rd_ignored");
        count_clear(1'b0, n);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL clear_access_ready: %b expected 1", ready); end
        rd(12'h010, 8'h00, "rd_010_after_clear");
    endtask

    task automatic test_sweep();
        int n;
        logic [9:0] bounds [8];
        bounds = '{10'h000, 10'h0FF, 10'h100, 10'h1FF, 10'h200, 10'h2FF, 10'h300, 10'h3FF};
        @(negedge clk); p_reset = 1'b0;
        count_clear(1'b1, n);
        check_cycles(n, 256, "sweep_clear_len");
        for (int i = 0; i < 8; i++) begin
            p_rd(bounds[i], 16'hBEEF, "sweep_boundary");
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_protect();
        test_back_to_back();
        test_reset_mid_clear();
        test_clear_access();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/banked_ram.md
BANKED_RAM -- requirements
Module: banked_ram

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12: total word address width (2^ADDR_WIDTH words).
REQ-002 The block SHALL have parameter BANK_BITS, default 3: bank-select width, giving NUM_BANKS = 2^BANK_BITS banks of 2^(ADDR_WIDTH-BANK_BITS) words each.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 8: word width.
REQ-004 The block SHALL have parameter CLEAR_ON_RESET, default 1: when 1, all memory is filled with FILL_VALUE after reset.
REQ-005 The block SHALL have parameter FILL_VALUE, default all-zeros, DATA_WIDTH bits: the clear pattern.
REQ-006 The block SHALL have port clock, input, 1 bit: sole clock, rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port address, input, ADDR_WIDTH bits: the upper BANK_BITS select the bank and the lower bits give the offset.
REQ-009 The block SHALL have port select, input, 1 bit: access request, active-high.
REQ-010 The block SHALL have port rw, input, 1 bit: 1 = read, 0 = write (6809 convention).
REQ-011 The block SHALL have port dataIn, input, DATA_WIDTH bits: write data.
REQ-012 The block SHALL have port writeProtect, input, NUM_BANKS bits: bit n high makes bank n read-only.
REQ-013 The block SHALL have port dataOut, output, DATA_WIDTH bits: registered read data.
REQ-014 The block SHALL have port ready, output, 1 bit: high when accesses are accepted.
REQ-015 The block SHALL have port protectFault, output, 1 bit: one-cycle pulse on a rejected write.

Function
REQ-016 The block SHALL implement a two-state machine: CLEAR and IDLE.
REQ-017 On reset deassertion, the block SHALL enter CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
REQ-018 In CLEAR, an offset counter SHALL start at 0 and, each cycle, write FILL_VALUE at that offset in all banks in parallel, then increment.
REQ-019 CLEAR SHALL go to IDLE in the cycle after the counter writes offset 2^(ADDR_WIDTH-BANK_BITS)-1; with defaults the clear takes exactly 512 cycles.
REQ-020 ready SHALL be 0 in CLEAR and 1 in IDLE (registered, changing with the state).
REQ-021 While ready=0, the block SHALL ignore select, rw and dataIn completely: no write, dataOut held, no protectFault.
REQ-022 A read SHALL occur on a rising edge with ready=1, select=1 and rw=1: dataOut takes the word at address; latency is 1 cycle.
REQ-023 dataOut SHALL hold its last value in every cycle with no accepted read.
REQ-024 A write SHALL occur on a rising edge with ready=1, select=1, rw=0 and writeProtect[bank]=0: the word at address becomes dataIn; dataOut is unchanged.
REQ-025 If ready=1, select=1, rw=0 and writeProtect[bank]=1, memory SHALL be unchanged and protectFault SHALL be 1 for exactly the following cycle.
REQ-026 Consecutive faulting writes SHALL keep protectFault high on each corresponding cycle.
REQ-027 writeProtect SHALL NOT block the CLEAR fill.
REQ-028 A read in the cycle after a write to the same address SHALL return the newly written data.
REQ-029 Each bank SHALL infer a separate block RAM; dataOut SHALL be selected using the registered bank index of the accepted read.

Reset
REQ-030 While reset=1, outputs SHALL be dataOut = all-ones, ready = 0, protectFault = 0, and the clear counter = 0.
REQ-031 Reset SHALL NOT directly alter memory contents.
REQ-032 A reset asserted mid-CLEAR SHALL abort the fill, and the fill SHALL restart from offset 0 after deassertion.
REQ-033 A reset asserted mid-access SHALL discard that access.

Verification
REQ-034 Reset release with defaults -> ready=0 for 512 cycles, then 1; reads of 0x000, 0x1FF, 0xE00 and 0xFFF then return 0x00.
REQ-035 Write 0xA5 to 0x3FF, then read 0x3FF -> dataOut=0xA5 one cycle after the read edge; a read of 0x5FF (another bank, same offset) returns 0x00.
REQ-036 writeProtect=8'b0000_0100, write 0x5A to 0x400 -> protectFault pulses 1 cycle; read 0x400 returns 0x00; the same write to 0x200 succeeds with no fault.
REQ-037 Reset asserted at clear cycle 100 -> ready stays 0; after release, a full 512-cycle clear runs, and a pre-seeded location reads 0x00.
REQ-038 Access attempts during CLEAR (write 0xFF to 0x010, read 0x010) -> no protectFault, dataOut stays 0xFF; after ready, a read of 0x010 returns 0x00.
REQ-039 Parameter sweep ADDR_WIDTH=10, BANK_BITS=2, DATA_WIDTH=16, FILL_VALUE=16'hBEEF -> clear takes 256 cycles; all bank boundary addresses read 0xBEEF.
